// File: rtl/comp_mult_pkg.sv
// Shared definitions for the comp_mult APB initiator: register map of the
// target register file, the start command word and the job FSM encoding.
package comp_mult_pkg;

  localparam logic [2:0] REG_OP1  = 3'd0;
  localparam logic [2:0] REG_OP2  = 3'd1;
  localparam logic [2:0] REG_RES  = 3'd2;
  localparam logic [2:0] REG_NR   = 3'd3;
  localparam logic [2:0] REG_CFG  = 3'd4;
  localparam logic [2:0] REG_STOP = 3'd5;
  localparam logic [2:0] REG_STS  = 3'd6;

  localparam logic [15:0] CFG_START = 16'd1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_OP1    = 4'd1,
    ST_WR_OP2    = 4'd2,
    ST_WR_RES    = 4'd3,
    ST_WR_NR     = 4'd4,
    ST_WR_START  = 4'd5,
    ST_POLL_RD   = 4'd6,
    ST_POLL_WAIT = 4'd7,
    ST_RD_STS    = 4'd8,
    ST_CLR       = 4'd9,
    ST_DONE      = 4'd10,
    ST_ERR       = 4'd11
  } state_t;

endpackage

// File: rtl/comp_mult_apb_xfer.sv
// Single-transfer APB engine. A req pulse loads a transfer into the output
// registers; psel stays high until pready, and a req on the completing edge
// chains the next transfer without dropping psel.
module comp_mult_apb_xfer
  import comp_mult_pkg::*;
#(
  parameter int SYS_AW = 16,
  parameter int REG_DW = 16
) (
  input  logic              clk,
  input  logic              sw_rst,
  input  logic              req,
  input  logic [SYS_AW-1:0] addr,
  input  logic              wr,
  input  logic [REG_DW-1:0] wdata,
  output logic              ack,
  output logic [REG_DW-1:0] rdata,
  output logic              err,
  output logic [SYS_AW-1:0] apb_paddr,
  output logic              apb_pwrite,
  output logic [REG_DW-1:0] apb_pwdata,
  output logic              apb_psel,
  input  logic              apb_pready,
  input  logic [REG_DW-1:0] apb_prdata,
  input  logic              apb_pslverr
);

  logic [SYS_AW-1:0] paddr_r;
  logic              pwrite_r;
  logic [REG_DW-1:0] pwdata_r;
  logic              psel_r;

  assign ack        = psel_r && apb_pready;
  assign err        = ack && apb_pslverr;
  assign rdata      = apb_prdata;
  assign apb_paddr  = paddr_r;
  assign apb_pwrite = pwrite_r;
  assign apb_pwdata = pwdata_r;
  assign apb_psel   = psel_r;

  // APB request registers: load on req, release psel on completion
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      psel_r   <= 1'b0;
      paddr_r  <= {SYS_AW{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= {REG_DW{1'b0}};
    end else if (req) begin
      psel_r   <= 1'b1;
      paddr_r  <= addr;
      pwrite_r <= wr;
      pwdata_r <= wdata;
    end else if (ack) begin
      psel_r   <= 1'b0;
    end
  end

endmodule

// File: rtl/comp_mult_apb_master.sv
// Job-level APB initiator for comp_mult_top: programs operands, starts the
// multiplier, polls the stop bit with idle gaps, reads status and clears stop.
module comp_mult_apb_master
  import comp_mult_pkg::*;
#(
  parameter int APB_BADDR = 1024,
  parameter int SYS_AW    = 16,
  parameter int REG_DW    = 16,
  parameter int POLL_GAP  = 4,
  parameter int POLL_MAX  = 1024
) (
  input  logic              clk,
  input  logic              sw_rst,
  input  logic              job_val,
  output logic              job_rdy,
  input  logic [SYS_AW-1:0] job_op1_ba,
  input  logic [SYS_AW-1:0] job_op2_ba,
  input  logic [SYS_AW-1:0] job_res_ba,
  input  logic [REG_DW-1:0] job_nr_op,
  output logic              done_val,
  output logic              done_err,
  output logic [REG_DW-1:0] done_sts,
  output logic [SYS_AW-1:0] apb_paddr,
  output logic              apb_pwrite,
  output logic [REG_DW-1:0] apb_pwdata,
  output logic              apb_psel,
  input  logic              apb_pready,
  input  logic [REG_DW-1:0] apb_prdata,
  input  logic              apb_pslverr
);

  localparam int PCW      = $clog2(POLL_MAX + 1);
  localparam int GCW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [SYS_AW-1:0] BADDR = SYS_AW'(APB_BADDR);

  state_t            state_r, state_s;
  logic [SYS_AW-1:0] op2_r, res_r;
  logic [REG_DW-1:0] nr_r;
  logic [PCW-1:0]    poll_cnt_r;
  logic [GCW-1:0]    gap_cnt_r;
  logic              job_rdy_r, done_val_r, done_err_r;
  logic [REG_DW-1:0] done_sts_r;

  logic              req_s, req_wr_s, accept_s, sts_cap_s, poll_inc_s;
  logic [2:0]        req_off_s;
  logic [REG_DW-1:0] req_wdata_s;
  logic [SYS_AW-1:0] req_addr_s;
  logic              xfer_ack_s, xfer_err_s;
  logic [REG_DW-1:0] xfer_rdata_s;

  assign req_addr_s = BADDR + SYS_AW'(req_off_s);
  assign job_rdy    = job_rdy_r;
  assign done_val   = done_val_r;
  assign done_err   = done_err_r;
  assign done_sts   = done_sts_r;

  comp_mult_apb_xfer #(.SYS_AW(SYS_AW), .REG_DW(REG_DW)) u_xfer (
    .clk         (clk),
    .sw_rst      (sw_rst),
    .req         (req_s),
    .addr        (req_addr_s),
    .wr          (req_wr_s),
    .wdata       (req_wdata_s),
    .ack         (xfer_ack_s),
    .rdata       (xfer_rdata_s),
    .err         (xfer_err_s),
    .apb_paddr   (apb_paddr),
    .apb_pwrite  (apb_pwrite),
    .apb_pwdata  (apb_pwdata),
    .apb_psel    (apb_psel),
    .apb_pready  (apb_pready),
    .apb_prdata  (apb_prdata),
    .apb_pslverr (apb_pslverr)
  );

  // Job FSM next state; a transfer request is issued on the edge that enters its state
  always_comb begin
    state_s     = state_r;
    req_s       = 1'b0;
    req_off_s   = REG_OP1;
    req_wr_s    = 1'b0;
    req_wdata_s = {REG_DW{1'b0}};
    accept_s    = 1'b0;
    sts_cap_s   = 1'b0;
    poll_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (job_val && job_rdy_r) begin
          accept_s = 1'b1;
          if (job_nr_op == {REG_DW{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WR_OP1; req_s = 1'b1; req_off_s = REG_OP1;
            req_wr_s = 1'b1; req_wdata_s = REG_DW'(job_op1_ba);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_OP1, ST_WR_OP2, ST_WR_RES, ST_WR_NR, ST_WR_START, ST_CLR: begin
        if (!xfer_ack_s) begin
          state_s = state_r;
        end else if (xfer_err_s) begin
          state_s = ST_ERR;
        end else begin
          req_s    = (state_r != ST_CLR);
          req_wr_s = (state_r != ST_WR_START) && (state_r != ST_CLR);
          case (state_r)
            ST_WR_OP1: begin state_s = ST_WR_OP2;   req_off_s = REG_OP2; req_wdata_s = REG_DW'(op2_r); end
            ST_WR_OP2: begin state_s = ST_WR_RES;   req_off_s = REG_RES; req_wdata_s = REG_DW'(res_r); end
            ST_WR_RES: begin state_s = ST_WR_NR;    req_off_s = REG_NR;  req_wdata_s = nr_r; end
            ST_WR_NR:  begin state_s = ST_WR_START; req_off_s = REG_CFG; req_wdata_s = REG_DW'(CFG_START); end
            ST_WR_START: begin state_s = ST_POLL_RD; req_off_s = REG_STOP; end
            default:   begin state_s = ST_DONE; end
          endcase
        end
      end
      ST_POLL_RD: begin
        if (!xfer_ack_s) begin
          state_s = ST_POLL_RD;
        end else if (xfer_err_s) begin
          state_s = ST_ERR;
        end else if (xfer_rdata_s[0]) begin
          state_s = ST_RD_STS; req_s = 1'b1; req_off_s = REG_STS;
        end else if (poll_cnt_r == PCW'(POLL_MAX - 1)) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_POLL_WAIT; poll_inc_s = 1'b1;
        end
      end
      ST_POLL_WAIT: begin
        if (gap_cnt_r == GCW'(GAP_LAST)) begin
          state_s = ST_POLL_RD; req_s = 1'b1; req_off_s = REG_STOP;
        end else begin
          state_s = ST_POLL_WAIT;
        end
      end
      ST_RD_STS: begin
        if (!xfer_ack_s) begin
          state_s = ST_RD_STS;
        end else if (xfer_err_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_CLR; sts_cap_s = 1'b1; req_s = 1'b1;
          req_off_s = REG_STOP; req_wr_s = 1'b1; req_wdata_s = {REG_DW{1'b0}};
        end
      end
      ST_DONE, ST_ERR: state_s = ST_IDLE;
      default:         state_s = ST_IDLE;
    endcase
  end

  // State, latched job fields, poll counters and registered job-side outputs
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_r    <= ST_IDLE;
      op2_r      <= {SYS_AW{1'b0}};
      res_r      <= {SYS_AW{1'b0}};
      nr_r       <= {REG_DW{1'b0}};
      poll_cnt_r <= {PCW{1'b0}};
      gap_cnt_r  <= {GCW{1'b0}};
      job_rdy_r  <= 1'b1;
      done_val_r <= 1'b0;
      done_err_r <= 1'b0;
      done_sts_r <= {REG_DW{1'b0}};
    end else begin
      state_r    <= state_s;
      job_rdy_r  <= (state_s == ST_IDLE);
      done_val_r <= (state_s == ST_DONE) || (state_s == ST_ERR);
      done_err_r <= (state_s == ST_ERR);
      gap_cnt_r  <= (state_r == ST_POLL_WAIT) ? gap_cnt_r + GCW'(1) : {GCW{1'b0}};
      if (accept_s) begin
        op2_r      <= job_op2_ba;
        res_r      <= job_res_ba;
        nr_r       <= job_nr_op;
        poll_cnt_r <= {PCW{1'b0}};
        done_sts_r <= {REG_DW{1'b0}};
      end else begin
        if (poll_inc_s) poll_cnt_r <= poll_cnt_r + PCW'(1);
        if (sts_cap_s)  done_sts_r <= xfer_rdata_s;
      end
    end
  end

endmodule

// File: tb/tb_comp_mult_apb_master.sv
// Directed bench for comp_mult_apb_master: a scripted APB slave logs every
// completed transfer; each job's access list, timing and done report are
// compared against hand-built expectations.
module tb_comp_mult_apb_master;

  logic        clk = 1'b0;
  logic        sw_rst;
  logic        job_val, job_rdy;
  logic [15:0] job_op1_ba, job_op2_ba, job_res_ba, job_nr_op;
  logic        done_val, done_err;
  logic [15:0] done_sts;
  logic [15:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_pwrite, apb_psel, apb_pready, apb_pslverr;

  always #5 clk = ~clk;

  comp_mult_apb_master #(.APB_BADDR(1024), .SYS_AW(16), .REG_DW(16),
                         .POLL_GAP(4), .POLL_MAX(8)) dut (
    .clk(clk), .sw_rst(sw_rst), .job_val(job_val), .job_rdy(job_rdy),
    .job_op1_ba(job_op1_ba), .job_op2_ba(job_op2_ba), .job_res_ba(job_res_ba),
    .job_nr_op(job_nr_op), .done_val(done_val), .done_err(done_err), .done_sts(done_sts),
    .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_psel(apb_psel), .apb_pready(apb_pready), .apb_prdata(apb_prdata),
    .apb_pslverr(apb_pslverr)
  );

  int n_vec = 0;
  int n_err = 0;

  // slave scripting and transfer log
  int          wait_cycles = 0;
  int          stop_at = 0;
  logic [15:0] err_addr = 16'hFFFF;
  logic [15:0] sts_val = 16'h0000;
  int          poll_num = 0;
  int          unstable = 0;
  int          cyc = 0;
  logic [32:0] log_e[$];
  int          log_c[$];
  logic [32:0] exp_q[$];

  // per-job observations
  logic        first_psel, first_done, got_done, d_err, d_psel;
  logic [15:0] first_addr, d_sts;
  int          d_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ent(input logic w, input logic [15:0] a, input logic [15:0] d);
    return {w, a, d};
  endfunction

  // APB slave: decides pready/prdata at the falling edge, logs completing transfers
  initial begin
    logic [32:0] hold_e;
    int          wait_left;
    logic        waiting;
    waiting = 1'b0; wait_left = 0; hold_e = '0;
    apb_pready = 1'b0; apb_prdata = 16'h0; apb_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (apb_psel === 1'b1) begin
        if (!waiting) begin
          hold_e = {apb_pwrite, apb_paddr, apb_pwdata};
          wait_left = wait_cycles;
          waiting = 1'b1;
        end else if ({apb_pwrite, apb_paddr, apb_pwdata} !== hold_e) begin
          unstable++;
        end
        if (wait_left == 0) begin
          apb_pready = 1'b1;
          waiting = 1'b0;
          apb_pslverr = (apb_paddr == err_addr);
          if (!apb_pwrite && apb_paddr == 16'd1029) begin
            poll_num++;
            apb_prdata = (stop_at != 0 && poll_num >= stop_at) ? 16'h8001 : 16'h8000;
          end else if (!apb_pwrite && apb_paddr == 16'd1030) begin
            apb_prdata = sts_val;
          end else begin
            apb_prdata = 16'h0000;
          end
          log_e.push_back({apb_pwrite, apb_paddr, apb_pwrite ? apb_pwdata : 16'h0000});
          log_c.push_back(cyc);
        end else begin
          apb_pready = 1'b0;
          apb_pslverr = 1'b0;
          wait_left--;
        end
      end else begin
        apb_pready = 1'b0;
        apb_pslverr = 1'b0;
        waiting = 1'b0;
      end
    end
  end

  task automatic start_job(input string tag, input logic [15:0] a, b, c, n);
    int k;
    k = 0;
    while (job_rdy !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
    log_e.delete(); log_c.delete(); poll_num = 0; unstable = 0;
    job_op1_ba = a; job_op2_ba = b; job_res_ba = c; job_nr_op = n; job_val = 1'b1;
    @(negedge clk); #1;
    job_val = 1'b0;
    check({tag, " accepted"}, 64'(job_rdy), 64'd0);
    first_psel = apb_psel; first_addr = apb_paddr; first_done = done_val;
  endtask

  task automatic wait_done(input string tag);
    got_done = 1'b0;
    for (int i = 0; i < 600 && !got_done; i++) begin
      if (done_val === 1'b1) begin
        got_done = 1'b1; d_err = done_err; d_sts = done_sts; d_psel = apb_psel; d_cyc = cyc;
      end else begin
        @(negedge clk); #1;
      end
    end
    check({tag, " done seen"}, 64'(got_done), 64'd1);
    @(negedge clk); #1;
    check({tag, " done one cycle"}, 64'(done_val), 64'd0);
    check({tag, " rdy after done"}, 64'(job_rdy), 64'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, " xfer count"}, 64'(log_e.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_e.size(); i++)
      check($sformatf("%s xfer[%0d]", tag, i), 64'(log_e[i]), 64'(exp_q[i]));
  endtask

  task automatic exp_writes(input logic [15:0] a, b, c, n, input int polls);
    exp_q.delete();
    exp_q.push_back(ent(1'b1, 16'd1024, a));
    exp_q.push_back(ent(1'b1, 16'd1025, b));
    exp_q.push_back(ent(1'b1, 16'd1026, c));
    exp_q.push_back(ent(1'b1, 16'd1027, n));
    exp_q.push_back(ent(1'b1, 16'd1028, 16'd1));
    for (int i = 0; i < polls; i++) exp_q.push_back(ent(1'b0, 16'd1029, 16'd0));
  endtask

  task automatic exp_tail();
    exp_q.push_back(ent(1'b0, 16'd1030, 16'd0));
    exp_q.push_back(ent(1'b1, 16'd1029, 16'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sw_rst = 1'b1; job_val = 1'b0;
    job_op1_ba = 16'h0; job_op2_ba = 16'h0; job_res_ba = 16'h0; job_nr_op = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset job_rdy", 64'(job_rdy), 64'd1);
    check("reset psel", 64'(apb_psel), 64'd0);
    check("reset paddr", 64'(apb_paddr), 64'd0);
    check("reset done", 64'({done_val, done_err, done_sts}), 64'd0);
    sw_rst = 1'b0;
    @(negedge clk); #1;

    // 1: nominal job, stop on third poll
    wait_cycles = 0; stop_at = 3; sts_val = 16'hA5C3;
    start_job("t1", 16'd100, 16'd200, 16'd300, 16'd10);
    check("t1 first psel", 64'(first_psel), 64'd1);
    check("t1 first paddr", 64'(first_addr), 64'd1024);
    wait_done("t1");
    exp_writes(16'd100, 16'd200, 16'd300, 16'd10, 3); exp_tail();
    check_seq("t1");
    if (log_c.size() == 10) begin
      check("t1 poll gap a", 64'(log_c[6] - log_c[5]), 64'd5);
      check("t1 poll gap b", 64'(log_c[7] - log_c[6]), 64'd5);
      check("t1 done timing", 64'(d_cyc - log_c[9]), 64'd1);
    end
    check("t1 done_err", 64'(d_err), 64'd0);
    check("t1 done_sts", 64'(d_sts), 64'hA5C3);

    // 2: same job with two wait states per access
    wait_cycles = 2; stop_at = 3; sts_val = 16'h0F0F;
    start_job("t2", 16'd100, 16'd200, 16'd300, 16'd10);
    wait_done("t2");
    exp_writes(16'd100, 16'd200, 16'd300, 16'd10, 3); exp_tail();
    check_seq("t2");
    check("t2 stable while waiting", 64'(unstable), 64'd0);
    check("t2 done_err", 64'(d_err), 64'd0);
    check("t2 done_sts", 64'(d_sts), 64'h0F0F);

    // 3: slave error on the nr_op write
    wait_cycles = 0; stop_at = 1; err_addr = 16'd1027;
    start_job("t3", 16'd11, 16'd22, 16'd33, 16'd44);
    wait_done("t3");
    err_addr = 16'hFFFF;
    exp_writes(16'd11, 16'd22, 16'd33, 16'd44, 0);
    void'(exp_q.pop_back());
    check_seq("t3");
    check("t3 psel at done", 64'(d_psel), 64'd0);
    if (log_c.size() > 0) check("t3 done timing", 64'(d_cyc - log_c[log_c.size() - 1]), 64'd1);
    check("t3 done_err", 64'(d_err), 64'd1);

    // 4: stop never set, timeout after 8 polls
    stop_at = 0;
    start_job("t4", 16'd1, 16'd2, 16'd3, 16'd4);
    wait_done("t4");
    exp_writes(16'd1, 16'd2, 16'd3, 16'd4, 8);
    check_seq("t4");
    check("t4 done_err", 64'(d_err), 64'd1);
    check("t4 done_sts", 64'(d_sts), 64'd0);

    // 5: soft reset during the poll gap, then a normal job
    stop_at = 0;
    start_job("t5", 16'd7, 16'd8, 16'd9, 16'd5);
    for (int i = 0; i < 200 && log_e.size() < 6; i++) begin @(negedge clk); #1; end
    check("t5 reached poll", 64'(log_e.size()), 64'd6);
    @(negedge clk); #1;
    check("t5 in poll gap", 64'(apb_psel), 64'd0);
    sw_rst = 1'b1;
    @(negedge clk); #1;
    sw_rst = 1'b0;
    check("t5 psel after reset", 64'(apb_psel), 64'd0);
    check("t5 rdy after reset", 64'(job_rdy), 64'd1);
    check("t5 no done on reset", 64'(done_val), 64'd0);
    repeat (8) begin @(negedge clk); #1; end
    check("t5 no traffic after reset", 64'(log_e.size()), 64'd6);
    stop_at = 2; sts_val = 16'h1234;
    start_job("t5b", 16'd5, 16'd6, 16'd7, 16'd8);
    wait_done("t5b");
    exp_writes(16'd5, 16'd6, 16'd7, 16'd8, 2); exp_tail();
    check_seq("t5b");
    check("t5b done_err", 64'(d_err), 64'd0);
    check("t5b done_sts", 64'(d_sts), 64'h1234);

    // 6: zero operations, no APB traffic
    start_job("t6", 16'd1, 16'd2, 16'd3, 16'd0);
    check("t6 done next cycle", 64'(first_done), 64'd1);
    check("t6 no psel", 64'(first_psel), 64'd0);
    wait_done("t6");
    check("t6 xfer count", 64'(log_e.size()), 64'd0);
    check("t6 done_err", 64'(d_err), 64'd0);
    check("t6 done_sts", 64'(d_sts), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
